// File: rtl/clock_ctrl_pkg.sv
// Shared types and default timing for the clock-set controller.
// State and select encodings, default divider constants, width helper.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  typedef enum logic {
    SEL_MIN  = 1'b0,
    SEL_HOUR = 1'b1
  } sel_t;

  localparam int TICK_DIV_DEF     = 100000000;
  localparam int REPEAT_DELAY_DEF = 50000000;
  localparam int REPEAT_RATE_DEF  = 10000000;

  // Counter width for a 0..n-1 range, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_set_controller_tick_prescaler.sv
// Seconds prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, rst_n, hold (clears and freezes count), tick.
module tick_prescaler
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-to-command sequencer with hold auto-repeat and 1 Hz tick.
// In: CLK100MHZ, RESET_N, MIN/HOUR/CLR_BTN, RUN_EN. Out: SEC_TICK,
// INC_MIN, INC_HOUR, CLR_TIME, SETTING, STATE.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic       MIN_BTN,
  input  logic       HOUR_BTN,
  input  logic       CLR_BTN,
  input  logic       RUN_EN,
  output logic       SEC_TICK,
  output logic       INC_MIN,
  output logic       INC_HOUR,
  output logic       CLR_TIME,
  output logic       SETTING,
  output logic [1:0] STATE
);

  localparam int TW = cnt_w(max_i(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

  state_t        state, state_n;
  sel_t          sel, sel_n;
  logic [TW-1:0] timer, timer_n;
  logic          inc_min_n, inc_hour_n, clr_n;
  logic          sel_btn, any_btn;

  assign sel_btn = (sel == SEL_HOUR) ? HOUR_BTN : MIN_BTN;
  assign any_btn = MIN_BTN | HOUR_BTN | CLR_BTN;

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    timer_n    = timer;
    inc_min_n  = 1'b0;
    inc_hour_n = 1'b0;
    clr_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (CLR_BTN) begin
          clr_n   = 1'b1;
          state_n = WAIT_REL;
        end else if (HOUR_BTN) begin
          inc_hour_n = 1'b1;
          sel_n      = SEL_HOUR;
          timer_n    = '0;
          state_n    = HOLD;
        end else if (MIN_BTN) begin
          inc_min_n = 1'b1;
          sel_n     = SEL_MIN;
          timer_n   = '0;
          state_n   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (CLR_BTN) begin
          clr_n   = 1'b1;
          state_n = WAIT_REL;
        end else if (!sel_btn) begin
          // other INC button still down: wait for full release
          state_n = any_btn ? WAIT_REL : IDLE;
        end else if ((state == HOLD && timer == DLY_LAST) ||
                     (state == REPEAT && timer == RATE_LAST)) begin
          inc_min_n  = (sel == SEL_MIN);
          inc_hour_n = (sel == SEL_HOUR);
          timer_n    = '0;
          state_n    = REPEAT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!any_btn) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      sel      <= SEL_MIN;
      timer    <= '0;
      INC_MIN  <= 1'b0;
      INC_HOUR <= 1'b0;
      CLR_TIME <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      timer    <= timer_n;
      INC_MIN  <= inc_min_n;
      INC_HOUR <= inc_hour_n;
      CLR_TIME <= clr_n;
    end
  end

  assign SETTING = (state != IDLE);
  assign STATE   = state;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (CLK100MHZ),
    .rst_n(RESET_N),
    .hold (SETTING | ~RUN_EN),
    .tick (SEC_TICK)
  );

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Control/sequencing block for the wall-clock time-keeping datapath. It converts debounced MIN/HOUR/CLR button levels into single-cycle increment and clear commands, with press-and-hold auto-repeat and fixed priority between requesters. It also generates the 1 Hz seconds-tick enable, which is paused while the time is being set. It sits between the Debounce instances and the time counters.

Parameters:
TICK_DIV, 100000000, clock cycles per SEC_TICK (1 s at 100 MHz)
REPEAT_DELAY, 50000000, cycles from the first pulse to the first auto-repeat pulse (0.5 s)
REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses (0.1 s)

Ports:
CLK100MHZ  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
MIN_BTN  in  1  debounced minute button level
HOUR_BTN  in  1  debounced hour button level
CLR_BTN  in  1  debounced clear-time button level
RUN_EN  in  1  enables seconds ticking
SEC_TICK  out  1  one-cycle pulse, once per TICK_DIV cycles
INC_MIN  out  1  one-cycle minute increment command
INC_HOUR  out  1  one-cycle hour increment command
CLR_TIME  out  1  one-cycle clear command to the time counters
SETTING  out  1  high while state != IDLE
STATE  out  2  current FSM state (debug)

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All outputs are 0.
  - State is IDLE; repeat timer, prescaler and the sel register are 0.
- All outputs are registered. A command pulse appears in the cycle after the condition is sampled (1-cycle latency from button level to pulse).
- FSM states: IDLE=0, HOLD=1, REPEAT=2, WAIT_REL=3.
- IDLE (priority CLR > HOUR > MIN):
  - CLR_BTN -> pulse CLR_TIME, go WAIT_REL.
  - else HOUR_BTN -> pulse INC_HOUR, sel=HOUR, timer=0, go HOLD.
  - else MIN_BTN -> pulse INC_MIN, sel=MIN, timer=0, go HOLD.
  - IDLE acts on levels. It is entered only with all buttons released, except after reset: a button already held at reset release is treated as a new press.
- HOLD / REPEAT, evaluated in this priority order:
  1. CLR_BTN high -> pulse CLR_TIME, go WAIT_REL. No INC pulse in the same cycle.
  2. Selected button low -> go IDLE if all buttons are low, else go WAIT_REL. No pulse.
  3. HOLD: timer == REPEAT_DELAY-1 -> pulse the selected INC, timer=0, go REPEAT.
  4. REPEAT: timer == REPEAT_RATE-1 -> pulse the selected INC, timer=0.
  5. Otherwise timer increments.
- The non-selected INC button is ignored throughout HOLD/REPEAT.
- WAIT_REL: MIN_BTN, HOUR_BTN and CLR_BTN all low -> IDLE. Otherwise stay; no pulses.
- INC_MIN, INC_HOUR and CLR_TIME are mutually exclusive. At most one is high in any cycle.
- Prescaler, count range 0..TICK_DIV-1:
  - If SETTING=1 or RUN_EN=0: count held at 0, SEC_TICK=0.
  - Else count increments. When count == TICK_DIV-1, count wraps to 0 and SEC_TICK=1 in the next cycle.
  - First tick comes exactly TICK_DIV cycles after enable; interval is exactly TICK_DIV cycles.
  - Leaving a setting operation restarts the second from 0.
- Widths:
  - Timer is $clog2(max(REPEAT_DELAY, REPEAT_RATE)) bits.
  - Prescaler is $clog2(TICK_DIV) bits.
  - Compares are done at full width; no overflow is possible.

Decomposition:
- Package clock_ctrl_pkg holds:
  - State encodings IDLE/HOLD/REPEAT/WAIT_REL (2-bit).
  - sel encoding SEL_MIN=0, SEL_HOUR=1.
  - Default timing constants.
- Sub-module tick_prescaler: holds the TICK_DIV counter, with a hold input (SETTING | !RUN_EN) and the SEC_TICK output.
- The FSM and repeat timer live in the top module.

Test Plan:
All scenarios use TICK_DIV=10, REPEAT_DELAY=8, REPEAT_RATE=4.
1. Reset, then RUN_EN=1 for 35 cycles -> SEC_TICK single-cycle pulses at +10, +20, +30; no INC/CLR pulses.
2. MIN_BTN high for 20 cycles, then low -> INC_MIN at +1, +9, +13, +17 (4 pulses); SETTING high throughout; no SEC_TICK; IDLE after release; prescaler restarts at 0.
3. MIN_BTN and HOUR_BTN rise in the same cycle, held 3 cycles -> exactly one INC_HOUR, zero INC_MIN; IDLE after both low.
4. MIN held into REPEAT, then CLR_BTN pulsed high -> exactly one CLR_TIME, no further INC_MIN; stays WAIT_REL until MIN and CLR both low.
5. MIN held, HOUR raised mid-HOLD, then MIN released while HOUR held -> no INC_HOUR; state WAIT_REL until HOUR low, then IDLE.
6. RESET_N asserted mid-REPEAT (between clock edges) -> all outputs 0 and STATE=0 immediately. Release with MIN still high -> INC_MIN one cycle after the first active edge.
